// File: rtl/byte_to_word_buffer_pkg.sv
// byte_to_word_buffer_pkg: shared widths and helpers for the byte-to-word buffer
package byte_to_word_buffer_pkg;
   localparam int BYTE_W     = 8;
   localparam int WORD_BYTES = 4;
   localparam int WORD_W     = BYTE_W * WORD_BYTES;
   function automatic int clog2(input int v);
      int r;
      r = 0;
      while ((1 << r) < v) r++;
      return r;
   endfunction
endpackage

// File: rtl/byte_to_word_buffer_mem.sv
// byte_ring_mem: byte-write, wrapped 4-byte-read register array without reset
module byte_ring_mem
   import byte_to_word_buffer_pkg::*;
#(
   parameter int DEPTH = 16,
   parameter int PTR_W = clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              we,
   input  logic [PTR_W-1:0]  waddr,
   input  logic [BYTE_W-1:0] wdata,
   input  logic [PTR_W-1:0]  raddr,
   output logic [WORD_W-1:0] rdata
);
   logic [BYTE_W-1:0] mem [DEPTH];
   always_ff @(posedge clk)
      if (we) mem[waddr] <= wdata;
   // pointer-width adds wrap the read indices modulo DEPTH
   always_comb
      for (int i = 0; i < WORD_BYTES; i++)
         rdata[WORD_W-1-i*BYTE_W -: BYTE_W] = mem[raddr + PTR_W'(i)];
endmodule

// File: rtl/byte_to_word_buffer.sv
// byte_to_word_buffer: byte-in, word-out circular buffer with flush
module byte_to_word_buffer
   import byte_to_word_buffer_pkg::*;
#(
   parameter int DEPTH = 16,
   localparam int PTR_W = clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              flush,
   input  logic              in_valid,
   input  logic [BYTE_W-1:0] in_data,
   output logic              in_ready,
   output logic              out_valid,
   output logic [WORD_W-1:0] out_data,
   input  logic              out_ready,
   output logic [PTR_W:0]    level
);
   localparam logic [PTR_W:0] LVL_WORD = (PTR_W+1)'(WORD_BYTES);
   localparam logic [PTR_W:0] LVL_FULL = (PTR_W+1)'(DEPTH);
   logic [PTR_W-1:0] wr_ptr, rd_ptr;
   logic             push, pop;
   // ready/valid decode only the registered level, never same-cycle traffic
   assign in_ready  = level != LVL_FULL;
   assign out_valid = level >= LVL_WORD;
   assign push      = in_valid & in_ready;
   assign pop       = out_valid & out_ready;
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else begin
         wr_ptr <= push ? wr_ptr + 1'b1 : wr_ptr;
         rd_ptr <= pop ? rd_ptr + PTR_W'(WORD_BYTES) : rd_ptr;
         level  <= level + (PTR_W+1)'(push) - (pop ? LVL_WORD : '0);
      end
   byte_ring_mem #(.DEPTH(DEPTH), .PTR_W(PTR_W)) u_mem (
      .clk  (clk),
      .we   (push & ~flush),
      .waddr(wr_ptr),
      .wdata(in_data),
      .raddr(rd_ptr),
      .rdata(out_data)
   );
endmodule

// File: tb/tb_byte_to_word_buffer.sv
// tb_byte_to_word_buffer: queue-model checker plus directed scenarios
module tb_byte_to_word_buffer;
   logic        clk = 0, rst = 1, flush = 0, in_valid = 0, out_ready = 0;
   logic [7:0]  in_data = 0;
   logic        in_ready, out_valid;
   logic [31:0] out_data;
   logic [4:0]  level;
   int checks = 0, errors = 0;
   logic [7:0] q[$];

   byte_to_word_buffer dut (
      .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_data(in_data),
      .in_ready(in_ready), .out_valid(out_valid), .out_data(out_data),
      .out_ready(out_ready), .level(level)
   );

   always #5 clk = ~clk;

   task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
      checks++;
      if (a !== e) begin
         errors++;
         $display("FAIL %s: got %h expected %h", n, a, e);
      end
   endtask

   // reference: FIFO of bytes; space and word availability judged before the edge
   always @(posedge clk or posedge rst) begin
      bit p, o;
      if (rst || flush) q.delete();
      else begin
         p = in_valid && q.size() != 16;
         o = out_ready && q.size() >= 4;
         if (o) repeat (4) void'(q.pop_front());
         if (p) q.push_back(in_data);
      end
   end

   always @(negedge clk) begin
      chk("m_level", level, q.size());
      chk("m_in_ready", in_ready, q.size() != 16);
      chk("m_out_valid", out_valid, q.size() >= 4);
      if (q.size() >= 4) chk("m_out_data", out_data, {q[0], q[1], q[2], q[3]});
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask
   task automatic push(input logic [7:0] d);
      in_valid = 1; in_data = d; step(); in_valid = 0;
   endtask
   task automatic pop();
      out_ready = 1; step(); out_ready = 0;
   endtask
   task automatic do_flush();
      flush = 1; step(); flush = 0;
   endtask

   initial begin
      repeat (2) step();
      rst = 0;
      @(negedge clk);
      chk("rst_level", level, 0);
      chk("rst_in_ready", in_ready, 1);
      chk("rst_out_valid", out_valid, 0);
      // 1: first word
      push(8'h11); push(8'h22); push(8'h33);
      @(negedge clk);
      chk("t1_not_yet", out_valid, 0);
      push(8'h44);
      @(negedge clk);
      chk("t1_valid", out_valid, 1);
      chk("t1_data", out_data, 32'h11223344);
      chk("t1_level", level, 4);
      // 2: fill, blocked byte, pop frees space only afterwards
      do_flush();
      for (int i = 0; i < 16; i++) push(8'(i));
      in_valid = 1; in_data = 8'hEE;
      step(); step();
      chk("t2_full_level", level, 16);
      chk("t2_full_ready", in_ready, 0);
      out_ready = 1; step(); out_ready = 0;
      @(negedge clk);
      chk("t2_pop_level", level, 12);
      chk("t2_ready_back", in_ready, 1);
      chk("t2_data", out_data, 32'h04050607);
      step(); in_valid = 0;
      @(negedge clk);
      chk("t2_held_taken", level, 13);
      // 3: writes wrap past index 15; reads then continue from 0
      do_flush();
      for (int i = 0; i < 12; i++) push(8'hC0 + 8'(i));
      repeat (3) pop();
      push(8'hD0); push(8'hD1);
      push(8'hA0); push(8'hA1); push(8'hA2); push(8'hA3);
      push(8'hB0); push(8'hB1);
      @(negedge clk);
      chk("t3_word12", out_data, 32'hD0D1A0A1);
      chk("t3_level", level, 8);
      pop();
      @(negedge clk);
      chk("t3_word0", out_data, 32'hA2A3B0B1);
      // 4: simultaneous push and pop at level 5
      do_flush();
      for (int i = 1; i <= 5; i++) push(8'h50 + 8'(i));
      in_valid = 1; in_data = 8'h56; out_ready = 1; step();
      in_valid = 0; out_ready = 0;
      @(negedge clk);
      chk("t4_level", level, 2);
      chk("t4_valid", out_valid, 0);
      push(8'h57); push(8'h58);
      @(negedge clk);
      chk("t4_data", out_data, 32'h55565758);
      // 5: flush beats push and pop
      do_flush();
      for (int i = 0; i < 9; i++) push(8'h80 + 8'(i));
      flush = 1; in_valid = 1; in_data = 8'h99; out_ready = 1; step();
      flush = 0; in_valid = 0; out_ready = 0;
      @(negedge clk);
      chk("t5_level", level, 0);
      chk("t5_valid", out_valid, 0);
      push(8'h61); push(8'h62); push(8'h63); push(8'h64);
      @(negedge clk);
      chk("t5_data", out_data, 32'h61626364);
      // 6: asynchronous reset mid-burst
      do_flush();
      for (int i = 0; i < 7; i++) push(8'h70 + 8'(i));
      @(negedge clk);
      chk("t6_pre_level", level, 7);
      #2 rst = 1;
      #1;
      chk("t6_async_level", level, 0);
      chk("t6_async_ready", in_ready, 1);
      chk("t6_async_valid", out_valid, 0);
      step();
      rst = 0;
      push(8'hF1); push(8'hF2); push(8'hF3); push(8'hF4);
      @(negedge clk);
      chk("t6_data", out_data, 32'hF1F2F3F4);
      chk("t6_wr_idx", dut.wr_ptr, 4);
      step();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
